// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencing controller.
// Accepts one byte per valid/ready handshake, then steps the TX datapath
// through load / bit-wait / shift so that a whole frame is serialised:
// start, data, parity and one or two stops. Keeps the line high when idle.
module uart_tx_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_tx_en,
  input  logic [3:0]        cfg_data_bits,
  input  logic              cfg_two_stop,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic [DATA_W-1:0] dp_tx_data,
  output logic              dp_start_bits,
  output logic              dp_shift_bits,
  output logic              dp_wait_bit_en,
  output logic              dp_wait_bit_rst_n,
  input  logic              dp_wait_bit_done,
  input  logic              dp_tx,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BIT,
    SHIFT
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0]  frame_last, frame_last_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              tx_ready_nxt, tx_busy_nxt, tx_done_nxt, cfg_err_nxt;
  logic              start_nxt, shift_nxt, wait_en_nxt, wait_rst_n_nxt;
  logic              accept, bits_ok;

  assign accept  = (state == IDLE) && tx_valid && tx_ready;
  assign bits_ok = (cfg_data_bits >= 4'd5) && (cfg_data_bits <= 4'd8);

  // Line mux: the datapath contents are meaningless outside a frame.
  assign tx = tx_busy ? dp_tx : 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && bits_ok) state_nxt = LOAD;
      LOAD:    state_nxt = BIT;
      BIT:     if (dp_wait_bit_done) state_nxt = (bit_cnt == frame_last) ? IDLE : SHIFT;
      SHIFT:   state_nxt = BIT;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered controls.
  // frame_last holds N-1 (index of the final bit) so the end test is a plain compare.
  always_comb begin
    data_nxt       = dp_tx_data;
    frame_last_nxt = frame_last;
    cfg_err_nxt    = cfg_err;
    bit_cnt_nxt    = bit_cnt;
    tx_ready_nxt   = (state == IDLE) && (state_nxt == IDLE) && cfg_tx_en;
    tx_busy_nxt    = (state_nxt != IDLE);
    tx_done_nxt    = (state == BIT) && (state_nxt == IDLE);
    start_nxt      = (state_nxt == LOAD);
    shift_nxt      = (state_nxt == SHIFT);
    wait_en_nxt    = (state_nxt == BIT) || (state_nxt == SHIFT);
    wait_rst_n_nxt = (state_nxt == BIT);
    if (accept) begin
      data_nxt    = tx_data;
      bit_cnt_nxt = '0;
      if (bits_ok) begin
        frame_last_nxt = CNT_W'(cfg_data_bits) + CNT_W'(2) + CNT_W'(cfg_two_stop);
      end else begin
        cfg_err_nxt = 1'b1;
      end
    end
    if (state == SHIFT) begin
      bit_cnt_nxt = bit_cnt + CNT_W'(1);
    end
  end

  // Output and datapath-control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready          <= 1'b0;
      tx_busy           <= 1'b0;
      tx_done           <= 1'b0;
      dp_start_bits     <= 1'b0;
      dp_shift_bits     <= 1'b0;
      dp_wait_bit_en    <= 1'b0;
      dp_wait_bit_rst_n <= 1'b0;
      dp_tx_data        <= '0;
      cfg_err           <= 1'b0;
      bit_cnt           <= '0;
      frame_last        <= '0;
    end else begin
      tx_ready          <= tx_ready_nxt;
      tx_busy           <= tx_busy_nxt;
      tx_done           <= tx_done_nxt;
      dp_start_bits     <= start_nxt;
      dp_shift_bits     <= shift_nxt;
      dp_wait_bit_en    <= wait_en_nxt;
      dp_wait_bit_rst_n <= wait_rst_n_nxt;
      dp_tx_data        <= data_nxt;
      cfg_err           <= cfg_err_nxt;
      bit_cnt           <= bit_cnt_nxt;
      frame_last        <= frame_last_nxt;
    end
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Sequencing controller for the UART transmit datapath. Accepts one byte per valid/ready handshake and holds it stable for the whole frame. Drives the datapath load, shift and bit-timer controls so that a complete frame is serialised: start, data bits, parity, one or two stops. Sits between the TX FIFO/host interface and UART_tx_datapath, and forces the line idle-high whenever no frame is active.

Parameters:
DATA_W, 8, width of tx_data / captured byte
CNT_W, 4, width of internal bit counter (must hold 1+8+1+2=12)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg_tx_en  input  1  transmitter enable (from control CSR)
cfg_data_bits  input  4  data bits per frame, legal 5..8
cfg_two_stop  input  1  1 = two stop bits, 0 = one
tx_valid  input  1  upstream has a byte
tx_data  input  DATA_W  byte to send
tx_ready  output  1  controller can accept a byte
dp_tx_data  output  DATA_W  captured byte to datapath (stable for whole frame)
dp_start_bits  output  1  one-cycle load pulse to datapath shift register
dp_shift_bits  output  1  one-cycle shift pulse
dp_wait_bit_en  output  1  bit-timer enable
dp_wait_bit_rst_n  output  1  bit-timer reset, active-low
dp_wait_bit_done  input  1  bit-timer expiry pulse
dp_tx  input  1  serial output of datapath shift register
tx  output  1  UART line (idle high)
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at frame end
cfg_err  output  1  sticky: byte accepted with illegal cfg_data_bits

Behaviour:
- Reset (async, any state): state=IDLE, tx=1, tx_ready=0 (during reset), tx_busy=0, tx_done=0, dp_start_bits=0, dp_shift_bits=0, dp_wait_bit_en=0, dp_wait_bit_rst_n=0, dp_tx_data=0, cfg_err=0, bit_cnt=0.
- All control outputs registered; tx = tx_busy ? dp_tx : 1 (combinational mux, so the line is high while the datapath holds undefined contents after power-up).
- States: IDLE, LOAD, BIT, SHIFT.
- IDLE: tx_ready = cfg_tx_en; dp_wait_bit_rst_n=0. Handshake at edge where tx_valid & tx_ready: capture tx_data into dp_tx_data and latch frame length N = 1 + cfg_data_bits + 1 + (cfg_two_stop ? 2 : 1).
- If cfg_data_bits is not 5..8 at accept: byte consumed, cfg_err set, no frame (stay IDLE, no start pulse, tx stays 1).
- Legal accept -> LOAD: dp_start_bits=1 for exactly one cycle, tx_busy=1, bit_cnt=0, tx_ready=0.
- LOAD -> BIT next cycle: dp_wait_bit_rst_n=1, dp_wait_bit_en=1.
- BIT: hold until dp_wait_bit_done. On done: if bit_cnt==N-1, go to IDLE with tx_done=1 for one cycle, tx_busy=0, timer reset. Otherwise go to SHIFT.
- SHIFT (one cycle): dp_shift_bits=1, dp_wait_bit_rst_n=0 (timer restarts), bit_cnt+=1, then back to BIT.
- Bit period on tx = timer period + 1 cycle (SHIFT).
- Second stop bit comes from the serial fill of 1s into the shift register; the controller simply counts one extra bit period.
- Config inputs are sampled only at accept; changes mid-frame have no effect on the current frame.
- cfg_tx_en deassert mid-frame: frame completes, and no new accept until it is re-asserted.
- dp_wait_bit_done outside BIT is ignored.
- Back-to-back: tx_ready rises in the cycle after tx_done. Minimum one idle cycle between frames (tx=1).
- cfg_err cleared only by reset.

Test Plan:
- Reset, then cfg_tx_en=1, data_bits=8, one stop; send 0xA5 with a bench timer model pulsing done 4 cycles after enable -> exactly 1 start pulse, 10 shift pulses, 11 done events. tx sequence 0, 1,0,1,0,0,1,0,1 (data MSB first per datapath), parity, 1. tx_done pulses once.
- data_bits=5, two stops, byte 0x1F -> N=9: 8 shifts, tx high for the final two bit periods, tx_busy low after the 9th done.
- Two bytes with tx_valid held high -> second accept exactly 1 cycle after tx_done. tx=1 for that gap. No overlap of start pulses.
- cfg_data_bits=9, send byte -> tx_ready handshake completes, cfg_err=1, no dp_start_bits, tx stays 1. A following legal byte transmits normally.
- Assert rst_n=0 in the middle of bit 4 -> tx=1 and all dp_* controls 0 immediately (asynchronously). After release, a new frame starts cleanly from a new start bit.
- Change cfg_data_bits from 8 to 5 mid-frame and drop cfg_tx_en -> current frame still 11 bits. tx_ready stays 0 afterwards until cfg_tx_en=1.
